// File: rtl/aes_128_inv_iter.sv
// Iterative AES-128 decryption core: expands the key forward to K10, then runs ten
// inverse rounds while stepping the round key backward on the fly.
module aes_128_inv_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] ct,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt
);

   typedef enum logic [1:0] {IDLE, KEXP, DEC, HOLD} fsm_t;

   fsm_t         fsm, fsm_next;
   logic [127:0] rkey, blk;
   logic [7:0]   rcon;
   logic [3:0]   cnt;
   logic [127:0] key_next_fwd, key_next_bwd, sub_blk, round_out;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] a);
      return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one forward step: recover the previous w3 first, since w0 depends on it.
   function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++) begin
            acc = '0;
            for (int unsigned k = 0; k < 4; k++)
               acc = acc ^ gf_mul(coef[(k + 4 - r) % 4], s[127 - 8*(4*c + k) -: 8]);
            o[127 - 8*(4*c + r) -: 8] = acc;
         end
      return o;
   endfunction

   always_comb begin
      key_next_fwd = key_fwd(rkey, rcon);
      key_next_bwd = key_bwd(rkey, rcon);
      sub_blk      = inv_shift_sub(blk) ^ key_next_bwd;
      round_out    = (cnt == 4'd9) ? sub_blk : inv_mix_cols(sub_blk);
   end

   always_ff @(posedge clk) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm;
      in_ready = (fsm == IDLE) & ~rst;
      case (fsm)
         IDLE: if (in_valid)      fsm_next = KEXP;
         KEXP: if (cnt == 4'd9)   fsm_next = DEC;
         DEC:  if (cnt == 4'd9)   fsm_next = HOLD;
         HOLD: if (out_ready)     fsm_next = IDLE;
         default:                 fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rkey      <= '0;
         blk       <= '0;
         rcon      <= '0;
         cnt       <= '0;
         pt        <= '0;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               rkey <= key;
               blk  <= ct;
               rcon <= 8'h01;
               cnt  <= '0;
            end
            KEXP: begin
               rkey <= key_next_fwd;
               // rcon stays at 8'h36 on the last step: it seeds the backward schedule.
               if (cnt == 4'd9) begin
                  blk <= blk ^ key_next_fwd;
                  cnt <= '0;
               end else begin
                  rcon <= xtime(rcon);
                  cnt  <= cnt + 4'd1;
               end
            end
            DEC: begin
               rkey <= key_next_bwd;
               blk  <= round_out;
               rcon <= inv_xtime(rcon);
               cnt  <= cnt + 4'd1;
               if (cnt == 4'd9) begin
                  pt        <= round_out;
                  out_valid <= 1'b1;
                  cnt       <= '0;
               end
            end
            HOLD: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_128_inv_iter.sv
// Directed bench for aes_128_inv_iter using published AES-128 vectors.
module tb_aes_128_inv_iter;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] key, ct, pt;
   int           n_vec = 0;
   int           n_bad = 0;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   always #5 clk = ~clk;

   aes_128_inv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .ct        (ct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Leaves the bench one step after the accepting edge (E0 + 1).
   task automatic send(input string tag, input logic [127:0] k, input logic [127:0] c);
      int unsigned w;
      w = 0;
      while (!in_ready && w < 200) begin
         tick(1);
         w++;
      end
      check({tag, " in_ready"}, 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      key      = k;
      ct       = c;
      tick(1);
      in_valid = 1'b0;
      key      = rnd128();
      ct       = rnd128();
   endtask

   task automatic wait_out(output int unsigned lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick(1);
         lat++;
      end
   endtask

   task automatic recv(input string tag, input logic [127:0] exp, input int unsigned gap);
      check({tag, " out_valid"}, 128'(out_valid), 128'd1);
      check({tag, " pt"}, pt, exp);
      if (gap > 0) tick(gap);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      int unsigned  lat;
      logic         stable, ir_seen;
      logic [127:0] vk [4];
      logic [127:0] vc [4];
      logic [127:0] vp [4];

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; ct = '0;
      tick(3);
      check("reset in_ready", 128'(in_ready), 128'd0);
      check("reset out_valid", 128'(out_valid), 128'd0);
      check("reset pt", pt, 128'd0);
      rst = 1'b0;
      #1;
      check("post-reset in_ready", 128'(in_ready), 128'd1);

      send("c1", C1_KEY, C1_CT);
      wait_out(lat);
      check("c1 latency", 128'(lat), 128'd20);
      recv("c1", C1_PT, 0);
      check("c1 in_ready after release", 128'(in_ready), 128'd1);

      send("b", B_KEY, B_CT);
      tick(10);
      check("b K10", dut.rkey, B_K10);
      wait_out(lat);
      check("b latency", 128'(lat + 10), 128'd20);
      recv("b", B_PT, 2);

      send("zero", 128'd0, Z_CT);
      wait_out(lat);
      check("zero pt", pt, 128'd0);
      stable = 1'b1;
      ir_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) begin
            in_valid = 1'b1;
            key = C1_KEY;
            ct = C1_CT;
         end
         if (i == 11) in_valid = 1'b0;
         tick(1);
         if (pt !== 128'd0 || out_valid !== 1'b1) stable = 1'b0;
         if (in_ready !== 1'b0) ir_seen = 1'b1;
      end
      check("hold pt stable", 128'(stable), 128'd1);
      check("hold in_ready low", 128'(ir_seen), 128'd0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("hold release in_ready", 128'(in_ready), 128'd1);
      check("hold release out_valid", 128'(out_valid), 128'd0);
      tick(25);
      check("ignored in_valid", 128'(out_valid), 128'd0);

      send("abort", C1_KEY, C1_CT);
      tick(14);
      rst = 1'b1;
      #1;
      check("abort in_ready during rst", 128'(in_ready), 128'd0);
      tick(1);
      rst = 1'b0;
      #1;
      check("abort in_ready after rst", 128'(in_ready), 128'd1);
      check("abort out_valid", 128'(out_valid), 128'd0);
      tick(25);
      check("abort no output", 128'(out_valid), 128'd0);
      send("c1 again", C1_KEY, C1_CT);
      wait_out(lat);
      check("c1 again latency", 128'(lat), 128'd20);
      recv("c1 again", C1_PT, 0);

      vk[0] = B_KEY;  vc[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97; vp[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      vk[1] = B_KEY;  vc[1] = 128'hf5d3d58503b9699de785895a96fdbaaf; vp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      vk[2] = C1_KEY; vc[2] = C1_CT;                                   vp[2] = C1_PT;
      vk[3] = 128'd0; vc[3] = Z_CT;                                    vp[3] = 128'd0;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) begin
            tick($urandom_range(0, 3));
            send("stream", vk[i], vc[i]);
            wait_out(lat);
            check("stream latency", 128'(lat), 128'd20);
            recv("stream", vp[i], $urandom_range(0, 4));
         end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
